// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction-side bus request controller feeding the fetch FIFO.
// Issues word fetches, tracks outstanding beats, and drops stale responses.
module ibex_fetch_req_ctrl #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  output logic                busy_o,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_clear_o,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i
);

  localparam int unsigned CW = $clog2(2 * NUM_REQS + 1);

  typedef enum logic {
    IDLE,
    WAIT_GNT
  } state_e;

  state_e state_q;

  logic [31:2] fetch_addr_q;
  logic [31:2] stored_addr_q;
  logic [31:2] req_addr;
  logic        discard_pend_q;

  logic [NUM_REQS-1:0] outstanding_q, outstanding_d;
  logic [NUM_REQS-1:0] discard_q, discard_d;
  logic [NUM_REQS-1:0] out_s, disc_s, slot;

  logic [CW-1:0] fill;
  logic          room;
  logic          issue;
  logic          gnt_acc;
  logic          new_disc;

  function automatic logic [CW-1:0] popcnt(
    input logic [NUM_REQS-1:0] v
  );
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // A branch clears the FIFO, so its occupancy no longer limits issue.
  assign fill  = popcnt(fifo_busy_i) + popcnt(outstanding_q);
  assign room  = branch_i | (fill < CW'(NUM_REQS));
  assign issue = (state_q == IDLE) & req_i &
                 ~outstanding_q[NUM_REQS-1] & room;

  assign req_addr = branch_i ? addr_i[31:2] : fetch_addr_q;

  assign instr_req_o  = (state_q == WAIT_GNT) | issue;
  assign instr_addr_o = (state_q == WAIT_GNT) ?
                        {stored_addr_q, 2'b00} :
                        {req_addr, 2'b00};

  assign gnt_acc  = instr_gnt_i & instr_req_o;
  assign new_disc = (state_q == WAIT_GNT) &
                    (discard_pend_q | branch_i);

  assign busy_o       = (|outstanding_q) | instr_req_o;
  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = addr_i;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;
  assign fifo_valid_o = instr_rvalid_i & ~discard_q[0] & ~branch_i;

  always_comb begin
    out_s  = outstanding_q;
    disc_s = discard_q | (branch_i ? outstanding_q : '0);
    if (instr_rvalid_i) begin
      out_s  = out_s >> 1;
      disc_s = disc_s >> 1;
    end
    // Lowest free slot after the retire shift.
    slot = ~out_s & {out_s[NUM_REQS-2:0], 1'b1};
    outstanding_d = out_s;
    discard_d     = disc_s;
    if (gnt_acc) begin
      outstanding_d = out_s | slot;
      discard_d     = (disc_s & ~slot) | (new_disc ? slot : '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      fetch_addr_q   <= '0;
      stored_addr_q  <= '0;
      discard_pend_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (issue && gnt_acc) begin
            fetch_addr_q <= req_addr + 30'd1;
          end else if (issue) begin
            state_q        <= WAIT_GNT;
            stored_addr_q  <= req_addr;
            discard_pend_q <= 1'b0;
          end else if (branch_i) begin
            fetch_addr_q <= addr_i[31:2];
          end
        end
        WAIT_GNT: begin
          if (gnt_acc) begin
            state_q        <= IDLE;
            discard_pend_q <= 1'b0;
            if (branch_i) begin
              fetch_addr_q <= addr_i[31:2];
            end else if (!discard_pend_q) begin
              fetch_addr_q <= stored_addr_q + 30'd1;
            end
          end else if (branch_i) begin
            discard_pend_q <= 1'b1;
            fetch_addr_q   <= addr_i[31:2];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  a_rvalid_tracked: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    instr_rvalid_i |-> outstanding_q[0]);

  a_gnt_not_full: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    instr_gnt_i |-> !outstanding_q[NUM_REQS-1]);

  a_gnt_with_req: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    instr_gnt_i |-> instr_req_o);

endmodule

// File: doc/ibex_fetch_req_ctrl.md
# ibex_fetch_req_ctrl

Instruction-side bus request controller that sits directly upstream of the fetch FIFO. It issues word-aligned fetch requests on the instruction memory interface and tracks up to NUM_REQS outstanding transactions. It discards responses made stale by a branch and pushes surviving responses into the FIFO. It also drives the FIFO clear and the branch target address on redirects.

## Interface
- NUM_REQS, 2: maximum outstanding bus transactions; must match the FIFO's NUM_REQS.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  1  fetch enable; no new requests are issued while low.
- branch_i  in  1  redirect pulse; the target is on addr_i.
- addr_i  in  32  branch target, halfword aligned.
- busy_o  out  1  high while any transaction is outstanding or a request is pending.
- fifo_busy_i  in  NUM_REQS  upper-entry occupancy from the FIFO, thermometer coded.
- fifo_clear_o  out  1  equals branch_i.
- fifo_valid_o  out  1  pushes one response word into the FIFO.
- fifo_addr_o  out  32  equals addr_i; the FIFO samples it only on clear.
- fifo_rdata_o  out  32  equals instr_rdata_i.
- fifo_err_o  out  1  equals instr_err_i.
- instr_req_o  out  1  bus request.
- instr_gnt_i  in  1  bus grant.
- instr_addr_o  out  32  request address, bits [1:0] always 0.
- instr_rvalid_i  in  1  response valid; responses return in order.
- instr_rdata_i  in  32  response data.
- instr_err_i  in  1  response bus error.

## Operation
- State
  - fetch_addr_q[31:2]: next word to request.
  - stored_addr_q[31:2]: address held during a wait for grant.
  - outstanding_q[NUM_REQS-1:0]: thermometer vector of granted, unanswered transactions.
  - discard_q[NUM_REQS-1:0]: discard flag per outstanding slot, aligned with outstanding_q.
  - discard_pend_q: discard flag for a request that is pending but not yet granted.
- FSM states: IDLE and WAIT_GNT.
- Issue condition in IDLE:
  - Requires req_i and ~outstanding_q[NUM_REQS-1].
  - Also requires popcount(fifo_busy_i) + popcount(outstanding_q) < NUM_REQS.
  - When branch_i is high, the FIFO-occupancy term is ignored because the FIFO is being cleared.
- Request address in IDLE:
  - {addr_i[31:2],2'b00} when branch_i is high.
  - Otherwise {fetch_addr_q,2'b00}.
- IDLE with issue condition true:
  - instr_req_o=1 combinationally.
  - With instr_gnt_i: stay in IDLE and set fetch_addr_q = request address + 4.
  - Without instr_gnt_i: latch the address into stored_addr_q and go to WAIT_GNT.
- WAIT_GNT:
  - instr_req_o=1 and instr_addr_o=stored_addr_q, both held stable until grant, regardless of req_i or branch_i.
  - branch_i in this state sets discard_pend_q and loads fetch_addr_q with the target word.
  - On grant: go to IDLE. If discard_pend_q is clear, fetch_addr_q = stored_addr_q+4; if set, fetch_addr_q keeps the target.
- Grant: shifts a 1 into the next free slot of outstanding_q. That slot's discard flag is taken from discard_pend_q, or from branch_i if the grant lands in the branch cycle while in WAIT_GNT.
- Response: instr_rvalid_i retires slot 0. outstanding_q and discard_q shift down by one.
- FIFO push: fifo_valid_o = instr_rvalid_i & ~discard_q[0] & ~branch_i.
- Branch: sets discard_q for every currently outstanding slot. fifo_clear_o is high in the same cycle.
- Address arithmetic is modulo 2^32: 0xFFFF_FFFC + 4 wraps to 0x0000_0000.
- busy_o = |outstanding_q | instr_req_o.

## Timing
- Reset values:
  - Outputs: instr_req_o=0, instr_addr_o=0, fifo_valid_o=0, busy_o=0. fifo_clear_o follows branch_i.
  - State: all vectors 0, FSM in IDLE, fetch_addr_q=0.
- Reset mid-transaction drops all tracking. Responses arriving after reset with no outstanding slot are illegal, and an assertion checks this.
- A branch in IDLE with space issues the target request in the same cycle, so the target can be granted on cycle 0.
- Response-to-FIFO latency is 0 cycles (combinational pass-through).
- Grant and response in the same cycle: the shift-down and the set happen together and the count is unchanged.
- Grant is only valid while instr_req_o=1. Assertions:
  - instr_rvalid_i implies outstanding_q[0].
  - Grant never arrives when outstanding_q is full.

## Test plan
- Reset, req_i=1, branch to 0x100, gnt every cycle, rvalid one cycle after gnt:
  - Requests go out to 0x100, 0x104, and then 0x108 once the FIFO drains.
  - Each response is pushed with fifo_valid_o=1.
  - The number of outstanding transactions never exceeds 2.
- fifo_busy_i=2'b11 with req_i=1 -> instr_req_o stays 0 until busy drops to 2'b01; then one request is issued.
- Request to 0x200 held 3 cycles without gnt, branch to 0x402 in cycle 2:
  - instr_addr_o stays 0x200 until grant.
  - The 0x200 response is discarded (fifo_valid_o=0).
  - The next request is to 0x400; fifo_addr_o=0x402 in the branch cycle.
- Two outstanding (0x10, 0x14), then branch to 0x80:
  - Both responses are dropped.
  - The first pushed word comes from 0x80.
- rvalid with instr_err_i=1 -> fifo_err_o=1 and fifo_valid_o=1 in the same cycle. Fetching continues at the next word.
- Fetch across 0xFFFF_FFFC -> the next request address is 0x0000_0000. Separately, asserting rst_ni=0 while one transaction is outstanding -> all outputs return to their reset values.
